// File: rtl/fir_pkg.sv
// Shared defaults, default coefficient set and controller state encoding for fir_serial_ctrl.
package fir_pkg;

  localparam int FIR_TAPS = 16;
  localparam int FIR_DW   = 16;
  localparam int FIR_ACCW = 32;

  // Symmetric low-pass set; also the values the coefficient registers reset to.
  localparam int COEF_DEFAULT [FIR_TAPS] = '{
    -58, 15, 601, 223, -2831, -2447, 10325, 26941,
    26941, 10325, -2447, -2831, 223, 601, 15, -58
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Taps beyond the default set (TAPS > FIR_TAPS) start at zero.
  function automatic int coef_default(input int idx);
    return (idx >= 0 && idx < FIR_TAPS) ? COEF_DEFAULT[idx] : 0;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-add: full-precision DW x DW product added to an ACCW-bit accumulator.
module fir_mac #(
  parameter int DW   = 16,
  parameter int ACCW = 32
) (
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  input  logic signed [ACCW-1:0] acc_i,
  output logic signed [ACCW-1:0] sum_o
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  assign prod     = a_i * b_i;
  // Size cast sign-extends (or truncates) the product; the sum wraps mod 2^ACCW.
  assign prod_ext = ACCW'(prod);
  assign sum_o    = acc_i + prod_ext;

endmodule

// File: rtl/fir_serial_ctrl.sv
// Serial FIR: one tap per cycle through a single MAC, valid/ready on both sides.
// Define FIR_COEF_WR_EN to add a coefficient write port (registers reset to the default set).
module fir_serial_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int DW   = FIR_DW,
  parameter int ACCW = FIR_ACCW,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [DW-1:0]   data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] data_out,
  output logic                   busy
`ifdef FIR_COEF_WR_EN
  ,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic signed [DW-1:0]   coef_wdata
`endif
);

  state_e                 state_q;
  logic [AW-1:0]          idx_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] mac_sum;
  logic signed [ACCW-1:0] data_out_q;
  logic                   out_valid_q;
  logic signed [DW-1:0]   tap_q [TAPS];
  logic signed [DW-1:0]   coef  [TAPS];

`ifdef FIR_COEF_WR_EN
  // Writes land only in IDLE, so a write alongside an accepted sample is seen by its MAC pass.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= DW'(coef_default(i));
    end else if (coef_we && state_q == IDLE) begin
      coef[coef_addr] <= coef_wdata;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < TAPS; i++) coef[i] = DW'(coef_default(i));
  end
`endif

  fir_mac #(
    .DW  (DW),
    .ACCW(ACCW)
  ) u_mac (
    .a_i  (coef[idx_q]),
    .b_i  (tap_q[idx_q]),
    .acc_i(acc_q),
    .sum_o(mac_sum)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      // NOTE: the delay line is reset element by element because an aborted pass must not leak old samples.
      for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            tap_q[0] <= data_in;
            for (int i = 1; i < TAPS; i++) tap_q[i] <= tap_q[i-1];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= mac_sum;
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(TAPS - 1)) state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; the handshake is only honoured once it is visible.
          if (!out_valid_q) begin
            data_out_q  <= acc_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Self-checking bench for fir_serial_ctrl: convolution model plus directed vectors.
// Coefficient-write vectors run only when FIR_COEF_WR_EN is defined.
module tb_fir_serial_ctrl;

  localparam int TAPS = 16;
  localparam int DW   = 16;
  localparam int ACCW = 32;
  localparam int LAT  = TAPS + 1;

  localparam int DEF_C [TAPS] = '{
    -58, 15, 601, 223, -2831, -2447, 10325, 26941,
    26941, 10325, -2447, -2831, 223, 601, 15, -58
  };

  logic                   CLK = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [DW-1:0]   data_in = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [ACCW-1:0] data_out;
  logic                   busy;
`ifdef FIR_COEF_WR_EN
  logic                   coef_we = 1'b0;
  logic [3:0]             coef_addr = '0;
  logic signed [DW-1:0]   coef_wdata = '0;
`endif

  fir_serial_ctrl #(.TAPS(TAPS), .DW(DW), .ACCW(ACCW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
`ifdef FIR_COEF_WR_EN
    ,
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accepts = 0;
  int m_coef [TAPS];
  int m_hist [TAPS];
  int exp_q [$];
  int edge_q [$];
  int results [$];
  bit prev_ov = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // y[n] = sum_k c[k] * x[n-k], wrapped to ACCW bits.
  function automatic int model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(m_coef[k]) * longint'(m_hist[k]);
    return int'(s);
  endfunction

  always @(posedge CLK) cyc++;

  // Single compare process: model update on accept, output checks every cycle.
  always @(negedge CLK) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        m_coef[k] = DEF_C[k];
        m_hist[k] = 0;
      end
      exp_q.delete();
      edge_q.delete();
      prev_ov = 1'b0;
    end else begin
      check("in_ready_vs_busy", in_ready, !busy);
`ifdef FIR_COEF_WR_EN
      if (coef_we && in_ready) m_coef[int'(coef_addr)] = int'(coef_wdata);
`endif
      if (in_valid && in_ready) begin
        for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = int'(data_in);
        exp_q.push_back(model_out());
        edge_q.push_back(cyc + 1);
        accepts++;
      end
      if (out_valid) begin
        check("in_ready_while_valid", in_ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!prev_ov) check("latency", cyc - edge_q[0], LAT);
          check("data_out", data_out, exp_q[0]);
          if (out_ready) begin
            results.push_back(int'(data_out));
            void'(exp_q.pop_front());
            void'(edge_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input int x);
    bit got = 1'b0;
    in_valid = 1'b1;
    data_in  = DW'(x);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept_in_time", got, 1);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_in_time", done, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_out_valid();
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("out_valid_in_time", got, 1);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int base;
    int a0;
    logic signed [ACCW-1:0] held;
    bit seen;

    // Reset state
    repeat (2) @(negedge CLK);
    check("init_out_valid", out_valid, 0);
    check("init_busy", busy, 0);
    check("init_data_out", data_out, 0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    check("init_in_ready", in_ready, 1);
    @(posedge CLK);
    #1;

    // Impulse: outputs reproduce the coefficient set in order
    base = results.size();
    send(1);
    for (int i = 0; i < TAPS - 1; i++) send(0);
    drain();
    for (int i = 0; i < TAPS; i++) check("impulse_lit", results[base+i], DEF_C[i]);

    // Positive step: largest positive sum of the default set
    base = results.size();
    for (int i = 0; i < TAPS; i++) send(32767);
    drain();
    check("step_first_lit", results[base], -1900486);
    check("step_last_lit", results[base+15], 2147483646);

    // Negative step: 65538 * -32768 wraps to a positive value
    base = results.size();
    for (int i = 0; i < TAPS; i++) send(-32768);
    drain();
    check("wrap_last_lit", results[base+15], 2147418112);

    // Backpressure: result held, no accept while DONE is stalled
    out_ready = 1'b0;
    send(100);
    wait_out_valid();
    held = data_out;
    a0 = accepts;
    @(posedge CLK);
    #1;
    in_valid = 1'b1;
    data_in  = 16'sd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_data_stable", data_out, held);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    check("bp_no_accept", accepts, a0);
    @(posedge CLK);
    #1;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_valid_dropped", out_valid, 0);
    check("bp_data_kept", data_out, held);
    send(7);
    drain();

`ifdef FIR_COEF_WR_EN
    // Coefficient write in IDLE applies; write during MAC is ignored
    do_reset();
    @(posedge CLK);
    #1;
    coef_we    = 1'b1;
    coef_addr  = 4'd0;
    coef_wdata = 16'sd100;
    @(posedge CLK);
    #1;
    coef_we = 1'b0;
    base = results.size();
    send(1);
    coef_we    = 1'b1;
    coef_addr  = 4'd1;
    coef_wdata = 16'sd999;
    repeat (3) @(posedge CLK);
    #1;
    coef_we = 1'b0;
    for (int i = 0; i < TAPS - 1; i++) send(0);
    drain();
    check("cw_first_lit", results[base], 100);
    check("cw_second_lit", results[base+1], 15);
`endif

    // Reset at MAC cycle 7 aborts; defaults and empty taps afterwards
    send(1);
    repeat (6) @(posedge CLK);
    #1;
    reset = 1'b1;
    @(negedge CLK);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data_out", data_out, 0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    @(posedge CLK);
    #1;
    base = results.size();
    send(1);
    for (int i = 0; i < TAPS - 1; i++) send(0);
    drain();
    check("post_abort_first_lit", results[base], -58);
    check("post_abort_third_lit", results[base+2], 601);
    check("post_abort_last_lit", results[base+15], -58);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
